// File: rtl/pipeline_debug_controller_pkg.sv
// Shared definitions for the pipeline debug controller: command codes, FSM encoding, dump size.
// The DUMP_CNT state exists only when PIPE_DBG_CYCLE_COUNT_EN is defined.
package pipeline_debug_controller_pkg;

  localparam int unsigned DBG_NB_CMD = 3;
  localparam int unsigned DBG_N_REGS = 32;

  localparam logic [DBG_NB_CMD-1:0] CMD_RUN   = 3'd1;
  localparam logic [DBG_NB_CMD-1:0] CMD_STEP  = 3'd2;
  localparam logic [DBG_NB_CMD-1:0] CMD_DUMP  = 3'd3;
  localparam logic [DBG_NB_CMD-1:0] CMD_CLEAR = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RUN      = 3'd1,
    ST_STEP     = 3'd2,
    ST_DUMP     = 3'd3
`ifdef PIPE_DBG_CYCLE_COUNT_EN
    , ST_DUMP_CNT = 3'd4
`endif
  } dbg_state_e;

  // States in which a word is offered on the transmit stream.
  function automatic logic is_stream_state(input dbg_state_e s);
    logic r;
    case (s)
      ST_DUMP:     r = 1'b1;
`ifdef PIPE_DBG_CYCLE_COUNT_EN
      ST_DUMP_CNT: r = 1'b1;
`endif
      default:     r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/pipeline_debug_controller_dbg_cycle_counter.sv
// Free-running count of enabled pipeline cycles with synchronous clear; wraps modulo 2^NB.
// Compiled only when PIPE_DBG_CYCLE_COUNT_EN is defined.
`ifdef PIPE_DBG_CYCLE_COUNT_EN
module dbg_cycle_counter #(
  parameter int unsigned NB = 32
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          en_i,
  input  logic          clr_i,
  output logic [NB-1:0] count_o
);

  logic [NB-1:0] count_d;
  logic [NB-1:0] count_q;

  // Clear has priority; it never coincides with an enabled cycle in practice.
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = {NB{1'b0}};
    end else if (en_i) begin
      count_d = count_q + NB'(1);
    end else begin
      count_d = count_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= {NB{1'b0}};
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule
`endif

// File: rtl/pipeline_debug_controller.sv
// Debug sequencer for the five-stage pipeline: RUN/STEP/DUMP/CLEAR, stage enable, register dump stream.
// PIPE_DBG_CYCLE_COUNT_EN adds the enabled-cycle counter and a trailing count word on DUMP.
module pipeline_debug_controller
  import pipeline_debug_controller_pkg::*;
#(
  parameter int unsigned NB_DATA = 32,
  parameter int unsigned NB_REG  = 5,
  parameter int unsigned N_REGS  = DBG_N_REGS,
  parameter int unsigned NB_CMD  = DBG_NB_CMD
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_cmd_valid,
  input  logic [NB_CMD-1:0]  i_cmd,
  output logic               o_cmd_ready,
  input  logic               i_halt,
  output logic               o_pipe_enable,
  output logic               o_halted,
  output logic               o_dbg_reg_sel,
  output logic [NB_REG-1:0]  o_dbg_reg_addr,
  input  logic [NB_DATA-1:0] i_dbg_reg_data,
  output logic               o_tx_valid,
  output logic [NB_DATA-1:0] o_tx_data,
  input  logic               i_tx_ready,
  output logic [NB_DATA-1:0] o_cycle_count
);

  localparam logic [NB_REG-1:0] LAST_ADDR = NB_REG'(N_REGS - 1);

  dbg_state_e         state_q;
  logic               enable_q;
  logic               halted_q;
  logic [NB_REG-1:0]  addr_q;
  logic               cmd_fire_s;
  logic [NB_DATA-1:0] tx_data_s;

  assign cmd_fire_s = i_cmd_valid & o_cmd_ready;

  // Command sequencer; the stage enable is registered so it tracks RUN/STEP occupancy exactly.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q  <= ST_IDLE;
      enable_q <= 1'b0;
      halted_q <= 1'b0;
      addr_q   <= {NB_REG{1'b0}};
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (cmd_fire_s) begin
            case (i_cmd)
              CMD_RUN: begin
                if (!halted_q) begin
                  state_q  <= ST_RUN;
                  enable_q <= 1'b1;
                end
              end
              CMD_STEP: begin
                if (!halted_q) begin
                  state_q  <= ST_STEP;
                  enable_q <= 1'b1;
                end
              end
              CMD_DUMP: begin
                state_q <= ST_DUMP;
                addr_q  <= {NB_REG{1'b0}};
              end
              CMD_CLEAR: halted_q <= 1'b0;
              default: ;
            endcase
          end
        end
        ST_RUN: begin
          if (i_halt) begin
            halted_q <= 1'b1;
            enable_q <= 1'b0;
            state_q  <= ST_IDLE;
          end
        end
        ST_STEP: begin
          if (i_halt) begin
            halted_q <= 1'b1;
          end
          enable_q <= 1'b0;
          state_q  <= ST_IDLE;
        end
        ST_DUMP: begin
          if (i_tx_ready) begin
            if (addr_q == LAST_ADDR) begin
              addr_q <= {NB_REG{1'b0}};
`ifdef PIPE_DBG_CYCLE_COUNT_EN
              state_q <= ST_DUMP_CNT;
`else
              state_q <= ST_IDLE;
`endif
            end else begin
              addr_q <= addr_q + NB_REG'(1);
            end
          end
        end
`ifdef PIPE_DBG_CYCLE_COUNT_EN
        ST_DUMP_CNT: begin
          if (i_tx_ready) begin
            state_q <= ST_IDLE;
          end
        end
`endif
        default: begin
          state_q  <= ST_IDLE;
          enable_q <= 1'b0;
          addr_q   <= {NB_REG{1'b0}};
        end
      endcase
    end
  end

`ifdef PIPE_DBG_CYCLE_COUNT_EN
  logic               clear_s;
  logic [NB_DATA-1:0] cycle_count_s;

  assign clear_s = cmd_fire_s & (i_cmd == CMD_CLEAR);

  dbg_cycle_counter #(
    .NB (NB_DATA)
  ) u_cycle_counter (
    .clk_i   (i_clock),
    .rst_ni  (i_reset),
    .en_i    (enable_q),
    .clr_i   (clear_s),
    .count_o (cycle_count_s)
  );

  assign o_cycle_count = cycle_count_s;
`else
  assign o_cycle_count = {NB_DATA{1'b0}};
`endif

  // Stream word selection decodes the state register only, so it cannot glitch on command inputs.
  always_comb begin
    tx_data_s = {NB_DATA{1'b0}};
    case (state_q)
      ST_DUMP:     tx_data_s = i_dbg_reg_data;
`ifdef PIPE_DBG_CYCLE_COUNT_EN
      ST_DUMP_CNT: tx_data_s = cycle_count_s;
`endif
      default:     tx_data_s = {NB_DATA{1'b0}};
    endcase
  end

  assign o_cmd_ready    = (state_q == ST_IDLE);
  assign o_dbg_reg_sel  = (state_q == ST_DUMP);
  assign o_tx_valid     = is_stream_state(state_q);
  assign o_tx_data      = tx_data_s;
  assign o_pipe_enable  = enable_q;
  assign o_halted       = halted_q;
  assign o_dbg_reg_addr = addr_q;

endmodule

// File: tb/tb_pipeline_debug_controller.sv
// Randomized transaction-level bench for pipeline_debug_controller with a command/stream reference model.
// Honours PIPE_DBG_CYCLE_COUNT_EN for the cycle counter and trailing count word.
module tb_pipeline_debug_controller;

  localparam int NB_DATA = 32;
  localparam int NB_REG  = 5;
  localparam int N_REGS  = 32;
  localparam int NB_CMD  = 3;
`ifdef PIPE_DBG_CYCLE_COUNT_EN
  localparam int HAS_CNT = 1;
`else
  localparam int HAS_CNT = 0;
`endif

  logic               clk = 1'b0;
  logic               rst_n;
  logic               cmd_valid;
  logic [NB_CMD-1:0]  cmd;
  logic               cmd_ready;
  logic               halt;
  logic               pipe_en;
  logic               halted;
  logic               reg_sel;
  logic [NB_REG-1:0]  reg_addr;
  logic [NB_DATA-1:0] reg_data;
  logic               tx_valid;
  logic [NB_DATA-1:0] tx_data;
  logic               tx_ready;
  logic [NB_DATA-1:0] cycle_count;

  logic [NB_DATA-1:0] regs [N_REGS];
  assign reg_data = regs[reg_addr];

  pipeline_debug_controller dut (
    .i_clock        (clk),
    .i_reset        (rst_n),
    .i_cmd_valid    (cmd_valid),
    .i_cmd          (cmd),
    .o_cmd_ready    (cmd_ready),
    .i_halt         (halt),
    .o_pipe_enable  (pipe_en),
    .o_halted       (halted),
    .o_dbg_reg_sel  (reg_sel),
    .o_dbg_reg_addr (reg_addr),
    .i_dbg_reg_data (reg_data),
    .o_tx_valid     (tx_valid),
    .o_tx_data      (tx_data),
    .i_tx_ready     (tx_ready),
    .o_cycle_count  (cycle_count)
  );

  always #5 clk = ~clk;

  int          n_vec = 0;
  int          n_err = 0;
  logic        m_halted;
  logic [31:0] m_count;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_count();
    return (HAS_CNT != 0) ? m_count : 32'd0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check_eq({tag, "_ready"}, 32'(cmd_ready), 32'd1);
    check_eq({tag, "_en"}, 32'(pipe_en), 32'd0);
    check_eq({tag, "_valid"}, 32'(tx_valid), 32'd0);
    check_eq({tag, "_sel"}, 32'(reg_sel), 32'd0);
    check_eq({tag, "_halted"}, 32'(halted), 32'(m_halted));
    check_eq({tag, "_count"}, cycle_count, exp_count());
  endtask

  task automatic issue(input logic [NB_CMD-1:0] c);
    check_eq("accept_ready", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1;
    cmd       = c;
    halt      = 1'($urandom_range(0, 1));
    tick();
    cmd_valid = 1'b0;
    cmd       = NB_CMD'($urandom_range(0, 7));
  endtask

  task automatic noise_cmd();
    cmd_valid = 1'($urandom_range(0, 1));
    cmd       = NB_CMD'($urandom_range(0, 7));
  endtask

  // RUN lasting h+1 enabled cycles, halt raised in the last one.
  task automatic do_run(input int h);
    issue(3'd1);
    if (m_halted) begin
      halt = 1'b0;
      check_eq("run_halted_en", 32'(pipe_en), 32'd0);
      tick();
      check_idle("run_halted");
    end else begin
      for (int k = 0; k <= h; k++) begin
        check_eq("run_en", 32'(pipe_en), 32'd1);
        check_eq("run_ready", 32'(cmd_ready), 32'd0);
        halt = (k == h);
        noise_cmd();
        tick();
      end
      halt      = 1'b0;
      cmd_valid = 1'b0;
      m_count   = m_count + 32'(h + 1);
      m_halted  = 1'b1;
      check_idle("run_end");
    end
  endtask

  task automatic do_step();
    logic hb;
    issue(3'd2);
    if (m_halted) begin
      halt = 1'b0;
      check_eq("step_halted_en", 32'(pipe_en), 32'd0);
      tick();
      check_idle("step_halted");
    end else begin
      check_eq("step_en", 32'(pipe_en), 32'd1);
      hb = 1'($urandom_range(0, 1));
      halt = hb;
      noise_cmd();
      tick();
      halt      = 1'b0;
      cmd_valid = 1'b0;
      m_count   = m_count + 32'd1;
      if (hb) m_halted = 1'b1;
      check_idle("step_end");
    end
  endtask

  // mode 0: ready always high, 1: ready every other cycle, 2: random ready.
  task automatic do_dump(input int mode, input int stop_at);
    int   idx;
    int   cyc;
    int   total;
    logic rdy;
    logic [31:0] exp;
    issue(3'd3);
    total = N_REGS + HAS_CNT;
    idx = 0;
    cyc = 0;
    while (idx < total && cyc < 2000 && idx != stop_at) begin
      exp = (idx < N_REGS) ? regs[idx] : m_count;
      check_eq("dump_valid", 32'(tx_valid), 32'd1);
      check_eq("dump_data", tx_data, exp);
      check_eq("dump_sel", 32'(reg_sel), (idx < N_REGS) ? 32'd1 : 32'd0);
      check_eq("dump_addr", 32'(reg_addr), (idx < N_REGS) ? 32'(idx) : 32'd0);
      check_eq("dump_en", 32'(pipe_en), 32'd0);
      check_eq("dump_ready", 32'(cmd_ready), 32'd0);
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = 1'(cyc % 2);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      tx_ready = rdy;
      halt     = 1'($urandom_range(0, 1));
      noise_cmd();
      tick();
      if (rdy) idx++;
      cyc++;
    end
    tx_ready  = 1'b0;
    cmd_valid = 1'b0;
    halt      = 1'b0;
    if (stop_at < 0) begin
      check_eq("dump_words", 32'(idx), 32'(total));
      check_idle("dump_end");
      check_eq("dump_end_addr", 32'(reg_addr), 32'd0);
    end
  endtask

  task automatic do_clear();
    issue(3'd4);
    halt     = 1'b0;
    m_halted = 1'b0;
    m_count  = 32'd0;
    check_idle("clear");
  endtask

  initial begin
    int op;
    logic [2:0] nop_codes [4];
    nop_codes[0] = 3'd0;
    nop_codes[1] = 3'd5;
    nop_codes[2] = 3'd6;
    nop_codes[3] = 3'd7;
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd       = 3'd0;
    halt      = 1'b0;
    tx_ready  = 1'b0;
    m_halted  = 1'b0;
    m_count   = 32'd0;
    for (int k = 0; k < N_REGS; k++) regs[k] = 32'(k * 32'h11);

    tick();
    check_idle("reset");
    check_eq("reset_addr", 32'(reg_addr), 32'd0);
    check_eq("reset_data", tx_data, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    repeat (3) do_step();
    do_run(10);
    do_step();
    do_dump(0, -1);
    do_dump(1, -1);
    do_clear();
    do_run($urandom_range(0, 20));

    // Asynchronous reset in the middle of a dump.
    do_dump(0, 12);
    check_eq("mid_addr", 32'(reg_addr), 32'd12);
    #2;
    rst_n = 1'b0;
    #1;
    m_halted = 1'b0;
    m_count  = 32'd0;
    check_idle("async_rst");
    check_eq("async_rst_addr", 32'(reg_addr), 32'd0);
    check_eq("async_rst_data", tx_data, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    do_dump(0, -1);

    for (int it = 0; it < 60; it++) begin
      op = $urandom_range(0, 9);
      case (op)
        0, 1, 2: do_run($urandom_range(0, 20));
        3, 4:    do_step();
        5, 6: begin
          if ($urandom_range(0, 2) == 0)
            for (int k = 0; k < N_REGS; k++) regs[k] = $urandom;
          do_dump($urandom_range(0, 2), -1);
        end
        7:       do_clear();
        8: begin
          issue(nop_codes[$urandom_range(0, 3)]);
          check_idle("nop");
        end
        default: begin
          repeat ($urandom_range(1, 4)) begin
            halt = 1'($urandom_range(0, 1));
            tick();
            check_idle("gap");
          end
          halt = 1'b0;
        end
      endcase
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
